// File: rtl/vec_mag_seq.sv
// Multi-cycle vector magnitude unit: shift-add squarer for x^2+y^2 followed by an
// optional restoring square root, with start/busy/done handshake and clock enable.
module vec_mag_seq #(
    parameter int unsigned W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ena,
    input  logic           start,
    input  logic           mode,
    input  logic [W-1:0]   x_in,
    input  logic [W-1:0]   y_in,
    output logic           busy,
    output logic           done,
    output logic [2*W:0]   result,
    output logic           exact
);

    localparam int unsigned RW = 2 * W + 1;
    localparam int unsigned CW = $clog2(W + 1);

    typedef enum logic [1:0] {StIdle, StSqx, StSqy, StSqrt} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            mode_q, mode_d;
    logic [W-1:0]    y_q, y_d;
    logic [W-1:0]    mult_q, mult_d;
    logic [RW-1:0]   mcand_q, mcand_d;
    logic [RW-1:0]   acc_q, acc_d;
    logic [RW:0]     rad_q, rad_d;
    logic [W+2:0]    rem_q, rem_d;
    logic [W:0]      root_q, root_d;
    logic            done_q, done_d;
    logic [RW-1:0]   result_q, result_d;
    logic            exact_q, exact_d;

    logic [RW-1:0]   acc_sum;
    logic [W+2:0]    rem_shift;
    logic [W+2:0]    trial;
    logic            borrow;
    logic [W+2:0]    rem_new;
    logic [W:0]      root_new;

    // One shift-add step: add the shifted multiplicand when the current multiplier bit is set.
    assign acc_sum = acc_q + (mult_q[0] ? mcand_q : '0);

    // One restoring root step on the next bit pair of the radicand.
    assign rem_shift       = (rem_q << 2) | {{(W + 1){1'b0}}, rad_q[RW:RW-1]};
    assign {borrow, trial} = {1'b0, rem_shift} - {1'b0, root_q, 2'b01};
    assign rem_new         = borrow ? rem_shift : trial;
    assign root_new        = {root_q[W-1:0], ~borrow};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        y_d      = y_q;
        mult_d   = mult_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        rad_d    = rad_q;
        rem_d    = rem_q;
        root_d   = root_q;
        done_d   = 1'b0;
        result_d = result_q;
        exact_d  = exact_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    mode_d  = mode;
                    y_d     = y_in;
                    mult_d  = x_in;
                    mcand_d = {{(W + 1){1'b0}}, x_in};
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = StSqx;
                end
            end
            StSqx: begin
                acc_d   = acc_sum;
                mcand_d = mcand_q << 1;
                mult_d  = mult_q >> 1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(W - 1)) begin
                    mult_d  = y_q;
                    mcand_d = {{(W + 1){1'b0}}, y_q};
                    cnt_d   = '0;
                    state_d = StSqy;
                end
            end
            StSqy: begin
                acc_d   = acc_sum;
                mcand_d = mcand_q << 1;
                mult_d  = mult_q >> 1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(W - 1)) begin
                    cnt_d = '0;
                    if (mode_q) begin
                        result_d = acc_sum;
                        exact_d  = 1'b1;
                        done_d   = 1'b1;
                        state_d  = StIdle;
                    end else begin
                        rad_d   = {1'b0, acc_sum};
                        rem_d   = '0;
                        root_d  = '0;
                        state_d = StSqrt;
                    end
                end
            end
            StSqrt: begin
                rad_d  = rad_q << 2;
                rem_d  = rem_new;
                root_d = root_new;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(W)) begin
                    result_d = {{W{1'b0}}, root_new};
                    exact_d  = (rem_new == '0);
                    done_d   = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            mode_q   <= 1'b0;
            y_q      <= '0;
            mult_q   <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            rad_q    <= '0;
            rem_q    <= '0;
            root_q   <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
            exact_q  <= 1'b0;
        end else if (ena) begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            y_q      <= y_d;
            mult_q   <= mult_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            rad_q    <= rad_d;
            rem_q    <= rem_d;
            root_q   <= root_d;
            done_q   <= done_d;
            result_q <= result_d;
            exact_q  <= exact_d;
        end
    end

    assign busy   = (state_q != StIdle);
    assign done   = done_q;
    assign result = result_q;
    assign exact  = exact_q;

endmodule
